// File: rtl/display_mode_ctrl.sv
// Display mode controller: selects time, date, D-day or aux view from two
// buttons, and runs the D-day set mode with commit/abort pulses and inactivity
// timeouts driven by a 1 Hz tick.
module display_mode_ctrl #(
    parameter int unsigned VIEW_TIMEOUT = 10,
    parameter int unsigned SET_TIMEOUT  = 30,
    parameter int unsigned CNT_W        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_set,
    output logic [1:0] mode,
    output logic       set_dday,
    output logic       dday_commit,
    output logic       dday_abort
);

    typedef enum logic [2:0] {
        T_VIEW   = 3'd0,
        D_VIEW   = 3'd1,
        DD_VIEW  = 3'd2,
        AUX_VIEW = 3'd3,
        DD_SET   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] VIEW_LAST  = CNT_W'(VIEW_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SET_LAST   = CNT_W'(SET_TIMEOUT - 1);
    localparam bit               VIEW_TO_EN = (VIEW_TIMEOUT != 0);

    logic [2:0]       mode_sync;
    logic [2:0]       set_sync;
    logic             mode_ev;
    logic             set_ev;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       mode_nxt;
    logic             commit_nxt;
    logic             abort_nxt;

    // Two-flop synchronisers plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync <= 3'b000;
            set_sync  <= 3'b000;
        end else begin
            mode_sync <= {mode_sync[1:0], btn_mode};
            set_sync  <= {set_sync[1:0], btn_set};
        end
    end

    assign mode_ev = mode_sync[1] & ~mode_sync[2];
    assign set_ev  = set_sync[1] & ~set_sync[2];

    // Next-state, inactivity counter and output decode; set beats mode, presses beat ticks.
    always_comb begin
        state_nxt  = state;
        commit_nxt = 1'b0;
        abort_nxt  = 1'b0;
        cnt_nxt    = cnt;
        mode_nxt   = 2'b00;

        unique case (state)
            T_VIEW: begin
                if (!set_ev && mode_ev) state_nxt = D_VIEW;
            end
            D_VIEW, DD_VIEW, AUX_VIEW: begin
                if (set_ev) begin
                    if (state == DD_VIEW) state_nxt = DD_SET;
                end else if (mode_ev) begin
                    state_nxt = state_t'(3'((state + 3'd1) & 3'd3));
                end else if (tick_1hz && VIEW_TO_EN && cnt == VIEW_LAST) begin
                    state_nxt = T_VIEW;
                end
            end
            DD_SET: begin
                if (set_ev) begin
                    state_nxt  = DD_VIEW;
                    commit_nxt = 1'b1;
                end else if (!mode_ev && tick_1hz && cnt == SET_LAST) begin
                    state_nxt = DD_VIEW;
                    abort_nxt = 1'b1;
                end
            end
            default: state_nxt = T_VIEW;
        endcase

        if (mode_ev || set_ev || state_nxt != state || state == T_VIEW) begin
            cnt_nxt = '0;
        end else if (tick_1hz && cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        unique case (state_nxt)
            D_VIEW:   mode_nxt = 2'b01;
            DD_VIEW:  mode_nxt = 2'b10;
            AUX_VIEW: mode_nxt = 2'b11;
            DD_SET:   mode_nxt = 2'b10;
            default:  mode_nxt = 2'b00;
        endcase
    end

    // State, counter and registered Moore/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= T_VIEW;
            cnt         <= '0;
            mode        <= 2'b00;
            set_dday    <= 1'b0;
            dday_commit <= 1'b0;
            dday_abort  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mode        <= mode_nxt;
            set_dday    <= (state_nxt == DD_SET);
            dday_commit <= commit_nxt;
            dday_abort  <= abort_nxt;
        end
    end

endmodule

// File: doc/display_mode_ctrl.md
DISPLAY_MODE_CTRL -- requirements
Module: display_mode_ctrl

Parameters
REQ-001 VIEW_TIMEOUT, default 10, tick_1hz pulses without a button press before a non-time view returns to the time view; 0 disables the return.
REQ-002 SET_TIMEOUT, default 30, tick_1hz pulses without a button press before D-day set mode is aborted; must be at least 1.
REQ-003 CNT_W, default 6, inactivity counter width; must satisfy 2^CNT_W > max(VIEW_TIMEOUT, SET_TIMEOUT).

Interface
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 tick_1hz  input  1  one-clk-wide 1 Hz timebase pulse, synchronous to clk.
REQ-007 btn_mode  input  1  raw asynchronous button input, already debounced, high while pressed.
REQ-008 btn_set  input  1  raw asynchronous button input, already debounced, high while pressed.
REQ-009 mode  output  2  display select to the output mux: 00 time, 01 date, 10 D-day, 11 aux.
REQ-010 set_dday  output  1  high only while in D-day set mode.
REQ-011 dday_commit  output  1  one-clk pulse when D-day set mode is exited by btn_set.
REQ-012 dday_abort  output  1  one-clk pulse when D-day set mode is exited by timeout.

Function
REQ-013 Synchroniser: each button passes through its own 2-flop synchroniser (s1, s2) plus a delay flop (s3).
REQ-014 Press event = s2 & ~s3; exactly one event per press, regardless of hold length.
REQ-015 Event latency: a button level first sampled high into s1 at edge N shall update state and outputs at edge N+2.
REQ-016 States, registered, each with a Moore decode:
 - T_VIEW: mode=00, set_dday=0.
 - D_VIEW: mode=01, set_dday=0.
 - DD_VIEW: mode=10, set_dday=0.
 - AUX_VIEW: mode=11, set_dday=0.
 - DD_SET: mode=10, set_dday=1.
REQ-017 Mode event in a view state advances the view cyclically: T_VIEW -> D_VIEW -> DD_VIEW -> AUX_VIEW -> T_VIEW.
REQ-018 Set event in DD_VIEW enters DD_SET.
REQ-019 Set event in T_VIEW, D_VIEW or AUX_VIEW is ignored.
REQ-020 In DD_SET, a mode event is ignored for the state but still clears the inactivity counter.
REQ-021 In DD_SET, a set event returns to DD_VIEW and pulses dday_commit on the same edge.
REQ-022 Simultaneous set and mode events in the same cycle: set has priority and the mode event is discarded.
REQ-023 Inactivity counter: cleared on any press event and on every state change.
REQ-024 Otherwise the inactivity counter increments on tick_1hz while in any state except T_VIEW, and is held at 0 in T_VIEW.
REQ-025 In D_VIEW, DD_VIEW or AUX_VIEW, if VIEW_TIMEOUT != 0 and a tick arrives with counter == VIEW_TIMEOUT-1, the next state is T_VIEW.
REQ-026 In DD_SET, a tick arriving with counter == SET_TIMEOUT-1 returns to DD_VIEW and pulses dday_abort on the same edge.
REQ-027 A press event and a tick in the same cycle: the press wins, the counter clears and no timeout occurs.
REQ-028 The counter saturates and never wraps; timeout fires at most once per inactivity interval.
REQ-029 dday_commit and dday_abort are registered, mutually exclusive, and last exactly one clk.
REQ-030 mode and set_dday are driven directly from state flops, with no combinational path from the inputs.

Reset
REQ-031 rst_n low asynchronously forces: state=T_VIEW, mode=00, set_dday=0, dday_commit=0, dday_abort=0, counter=0, all synchroniser flops=0.
REQ-032 Reset asserted mid-DD_SET exits without a commit or abort pulse.
REQ-033 A button already held at reset release produces one event, 2 edges after release.
REQ-034 The block is operational on the first clk edge after rst_n deasserts.

Verification
REQ-035 Reset, then 4 separate btn_mode presses: mode = 01, 10, 11, 00, each update 2 edges after s1 samples the press; set_dday stays 0.
REQ-036 In DD_VIEW, press btn_set: mode=10 and set_dday=1. Press btn_set again: set_dday=0, dday_commit high for exactly 1 clk, mode stays 10.
REQ-037 In DD_SET, apply 30 ticks with no press: on the 30th tick set_dday=0 and dday_abort pulses for 1 clk. After 29 ticks plus a btn_mode press, the state is still DD_SET and the count restarts.
REQ-038 In D_VIEW, apply 10 ticks: mode returns to 00 on the 10th tick. A press coincident with the 10th tick: no return, and btn_mode advances the mode to 10.
REQ-039 In DD_VIEW, btn_set and btn_mode events in the same cycle: DD_SET is entered and mode stays 10. Holding btn_mode for 100 clk yields one advance only.
REQ-040 Assert rst_n low asynchronously (between clk edges) while in DD_SET: outputs immediately read mode=00, set_dday=0, with no dday_commit or dday_abort pulse.
